geiger_stack_receiver: RTL and testbench

GEIGER_STACK_RECEIVER -- requirements
Module: geiger_stack_receiver

---
 rtl/geiger_stack_receiver.sv | 115 +++++++++++
 tb/tb_geiger_stack_receiver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/geiger_stack_receiver.sv
// Geiger stack byte-stream receiver: hunts for SYNC_BYTE, gathers 10 payload
// bytes, verifies an XOR checksum and publishes the 80-bit stack.
module geiger_stack_receiver #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        CLK_1MHZ,
  input  logic        RESET,
  input  logic [7:0]  D_IN,
  input  logic        D_STROBE,
  output logic [79:0] G_DATA_STACK,
  output logic        G_DATA_VALID,
  output logic        FRAME_ERR,
  output logic [7:0]  ERR_COUNT,
  output logic        BUSY
);

  localparam int unsigned    TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [3:0]     r_idx;
  logic [7:0]     r_xor;
  logic [79:0]    r_shadow;
  logic [TW-1:0]  r_tmo;
  logic           w_timeout;
  logic           w_sync_hit;
  logic           w_accept;
  logic           w_reject;
  logic           w_err;

  assign BUSY = (r_state != HUNT);

  always_comb begin
    w_next     = r_state;
    w_sync_hit = 1'b0;
    w_accept   = 1'b0;
    w_reject   = 1'b0;
    // Counter would reach TIMEOUT_CYCLES on this idle cycle.
    w_timeout  = (r_state != HUNT) && !D_STROBE && (r_tmo == TMO_LAST);
    case (r_state)
      HUNT: begin
        if (D_STROBE && (D_IN == SYNC_BYTE)) begin
          w_sync_hit = 1'b1;
          w_next     = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (w_timeout)
          w_next = HUNT;
        else if (D_STROBE && (r_idx == 4'd9))
          w_next = CHECK;
      end
      CHECK: begin
        if (w_timeout) begin
          w_next = HUNT;
        end else if (D_STROBE) begin
          w_accept = (D_IN == r_xor);
          w_reject = (D_IN != r_xor);
          w_next   = HUNT;
        end
      end
      default: w_next = HUNT;
    endcase
    w_err = w_reject || w_timeout;
  end

  always_ff @(posedge CLK_1MHZ) begin
    if (!RESET) begin
      r_state      <= HUNT;
      r_idx        <= '0;
      r_xor        <= '0;
      r_shadow     <= '0;
      r_tmo        <= '0;
      G_DATA_STACK <= '0;
      G_DATA_VALID <= 1'b0;
      FRAME_ERR    <= 1'b0;
      ERR_COUNT    <= '0;
    end else begin
      r_state      <= w_next;
      G_DATA_VALID <= w_accept;
      FRAME_ERR    <= w_err;

      if (w_accept)
        G_DATA_STACK <= r_shadow;

      if (w_err && (ERR_COUNT != '1))
        ERR_COUNT <= ERR_COUNT + 8'd1;

      if ((r_state == HUNT) || D_STROBE || w_timeout)
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + TW'(1);

      if (w_sync_hit || w_timeout) begin
        r_idx    <= '0;
        r_xor    <= '0;
        r_shadow <= '0;
      end else if ((r_state == PAYLOAD) && D_STROBE) begin
        // Shifting in MSB-first lands payload byte k at [79-8k -: 8] after 10 bytes.
        r_shadow <= {r_shadow[71:0], D_IN};
        r_xor    <= r_xor ^ D_IN;
        r_idx    <= r_idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_geiger_stack_receiver.sv
// Scoreboard bench for geiger_stack_receiver: expected pulses are queued as
// checksum/timeout stimulus is driven and matched when the DUT pulses.
module tb_geiger_stack_receiver;

  localparam logic [7:0]  SYNC = 8'hA5;
  localparam int unsigned TMO  = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  d_in = '0;
  logic        d_strobe = 1'b0;
  logic [79:0] g_stack;
  logic        g_valid;
  logic        frame_err;
  logic [7:0]  err_count;
  logic        busy;

  geiger_stack_receiver #(
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK_1MHZ     (clk),
    .RESET        (rst_n),
    .D_IN         (d_in),
    .D_STROBE     (d_strobe),
    .G_DATA_STACK (g_stack),
    .G_DATA_VALID (g_valid),
    .FRAME_ERR    (frame_err),
    .ERR_COUNT    (err_count),
    .BUSY         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [79:0] stack;
    logic [7:0]  errs;
    int unsigned at;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cyc      = 0;
  logic [79:0] m_stack  = '0;
  logic [7:0]  m_errs   = '0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic monitor();
    exp_t e;
    while (q.size() != 0 && q[0].at < cyc) begin
      e = q.pop_front();
      chk("pulse_missing_at", 80'(cyc), 80'(e.at));
    end
    if (g_valid || frame_err) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {78'b0, g_valid, frame_err}, 80'b0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", {78'b0, g_valid, frame_err}, e.is_err ? 80'b01 : 80'b10);
        chk("pulse_cycle", 80'(cyc), 80'(e.at));
        chk("stack", g_stack, e.stack);
        chk("err_count", 80'(err_count), 80'(e.errs));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic send(input logic [7:0] b);
    d_in     = b;
    d_strobe = 1'b1;
    tick();
  endtask

  task automatic idle(input int unsigned n);
    d_strobe = 1'b0;
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic expect_pulse(input bit is_err, input int unsigned delay);
    exp_t e;
    if (is_err) begin
      if (m_errs != 8'hFF) m_errs = m_errs + 8'd1;
    end
    e.is_err = is_err;
    e.stack  = m_stack;
    e.errs   = m_errs;
    e.at     = cyc + delay;
    q.push_back(e);
  endtask

  task automatic send_frame(input logic [79:0] payload, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    x = '0;
    send(SYNC);
    for (int k = 0; k < 10; k++) begin
      b = payload[79 - 8*k -: 8];
      x = x ^ b;
      send(b);
    end
    if (!corrupt) m_stack = payload;
    expect_pulse(corrupt, 1);
    send(corrupt ? (x ^ 8'h07) : x);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] p;
    // Reset state
    rst_n = 1'b0;
    idle(2);
    chk("rst_stack", g_stack, 80'h0);
    chk("rst_flags", {77'b0, g_valid, frame_err, busy}, 80'h0);
    chk("rst_errs", 80'(err_count), 80'h0);
    rst_n = 1'b1;

    // Good frame
    send_frame(80'h0102030405060708090A, 1'b0);
    d_strobe = 1'b0;
    chk("good_stack", g_stack, 80'h0102030405060708090A);
    chk("good_busy", 80'(busy), 80'h0);
    idle(3);

    // Bad checksum (0C instead of 0B)
    send_frame(80'h0102030405060708090A, 1'b1);
    idle(2);
    chk("bad_errs", 80'(err_count), 80'h1);
    chk("bad_stack_held", g_stack, 80'h0102030405060708090A);

    // Timeout after two payload bytes
    send(SYNC);
    send(8'h01);
    send(8'h02);
    expect_pulse(1'b1, TMO);
    idle(TMO - 1);
    chk("tmo_busy_before", 80'(busy), 80'h1);
    idle(1);
    chk("tmo_busy_after", 80'(busy), 80'h0);
    chk("tmo_errs", 80'(err_count), 80'h2);
    send_frame(80'h1122334455667788AABB, 1'b0);
    idle(2);
    chk("after_tmo_stack", g_stack, 80'h1122334455667788AABB);

    // Hunt noise, then sync value embedded as payload byte 4
    send(8'h00);
    send(8'h33);
    send_frame(80'h10203040A5607080900F, 1'b0);
    idle(2);
    chk("embedded_sync_stack", g_stack, 80'h10203040A5607080900F);

    // Mid-frame reset after 5 payload bytes
    send(SYNC);
    for (int k = 1; k <= 5; k++) send(8'(k * 3));
    rst_n    = 1'b0;
    d_strobe = 1'b0;
    tick();
    m_stack = '0;
    m_errs  = '0;
    chk("midrst_stack", g_stack, 80'h0);
    chk("midrst_flags", {77'b0, g_valid, frame_err, busy}, 80'h0);
    chk("midrst_errs", 80'(err_count), 80'h0);
    rst_n = 1'b1;
    idle(2);
    send_frame(80'hDEADBEEF0123456789AB, 1'b0);
    idle(2);
    chk("after_rst_stack", g_stack, 80'hDEADBEEF0123456789AB);

    // Back-to-back frames with random payloads, then error saturation
    for (int i = 0; i < 4; i++) begin
      p = {$urandom, $urandom, 16'($urandom)};
      send_frame(p, 1'b0);
    end
    for (int i = 0; i < 260; i++) begin
      p = {$urandom, $urandom, 16'($urandom)};
      send_frame(p, 1'b1);
    end
    idle(3);
    chk("sat_errs", 80'(err_count), 80'hFF);
    chk("queue_drained", 80'(q.size()), 80'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
